// File: rtl/timer_count_dp_if.sv
// timer_count_dp_if
// Groups the control strobes, the setting input and the status/display
// outputs of the timer-set datapath.
//   master : controller side (drives tick, din, La, Lb, Lr, Er, Ea, Kc, s;
//            observes k7, a_min, b_sec, r_cnt, r_zero, done, disp_*)
//   slave  : datapath side (timer_count_dp)
interface timer_count_dp_if;
    logic        tick;
    logic [5:0]  din;
    logic        La;
    logic        Lb;
    logic        Lr;
    logic        Er;
    logic        Ea;
    logic        Kc;
    logic [1:0]  s;
    logic        k7;
    logic [5:0]  a_min;
    logic [5:0]  b_sec;
    logic [11:0] r_cnt;
    logic        r_zero;
    logic        done;
    logic [5:0]  disp_min;
    logic [5:0]  disp_sec;

    modport master (
        output tick, din, La, Lb, Lr, Er, Ea, Kc, s,
        input  k7, a_min, b_sec, r_cnt, r_zero, done, disp_min, disp_sec
    );

    modport slave (
        input  tick, din, La, Lb, Lr, Er, Ea, Kc, s,
        output k7, a_min, b_sec, r_cnt, r_zero, done, disp_min, disp_sec
    );
endinterface

// File: rtl/timer_count_dp.sv
// timer_count_dp
// Countdown-timer datapath: setting registers A (minutes) and B (seconds),
// remaining-seconds register R, 3-bit saturating tick counter K and a
// registered expiry pulse.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : timer_count_dp_if.slave
//          tick     1 Hz one-cycle strobe
//          din      setting value, saturated to 59 on load
//          La/Lb    load A/B from din
//          Lr       load R <= A*60+B (priority over decrement)
//          Er       enable countdown (paused while s[0]=1)
//          Ea       display select: 1 -> R as min/sec, 0 -> A/B
//          Kc       clear K
//          k7       K==7
//          a_min, b_sec, r_cnt, r_zero, done, disp_min, disp_sec
module timer_count_dp (
    input  logic             clk,
    input  logic             rst,
    timer_count_dp_if.slave  bus
);

    logic [5:0]  a_q;
    logic [5:0]  b_q;
    logic [11:0] r_q;
    logic [2:0]  k_q;
    logic        done_q;

    logic [5:0]  din_sat;
    logic [11:0] r_load;
    logic        dec_en;
    logic [11:0] r_div;
    logic [11:0] r_mod;

    assign din_sat = (bus.din > 6'd59) ? 6'd59 : bus.din;
    assign r_load  = ({6'd0, a_q} * 12'd60) + {6'd0, b_q};
    assign dec_en  = bus.Er && !bus.s[0] && bus.tick && !bus.Lr && (r_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
        end else begin
            if (bus.La) a_q <= din_sat;
            if (bus.Lb) b_q <= din_sat;

            // r_load uses the A/B values held before this edge.
            if (bus.Lr)
                r_q <= r_load;
            else if (dec_en)
                r_q <= r_q - 12'd1;

            // Only a decrement from 1 marks expiry; loading 0 does not.
            done_q <= dec_en && (r_q == 12'd1);

            if (bus.Kc)
                k_q <= '0;
            else if (bus.tick && (k_q != 3'd7))
                k_q <= k_q + 3'd1;
        end
    end

    assign r_div = r_q / 12'd60;
    assign r_mod = r_q % 12'd60;

    always_comb begin
        bus.disp_min = a_q;
        bus.disp_sec = b_q;
        if (bus.Ea) begin
            bus.disp_min = r_div[5:0];
            bus.disp_sec = r_mod[5:0];
        end
    end

    assign bus.a_min  = a_q;
    assign bus.b_sec  = b_q;
    assign bus.r_cnt  = r_q;
    assign bus.r_zero = (r_q == '0);
    assign bus.done   = done_q;
    assign bus.k7     = (k_q == 3'd7);

    // R <= 3599, so quotient and remainder both fit in 6 bits; s[1] has no function.
    logic unused;
    assign unused = &{1'b0, r_div[11:6], r_mod[11:6], bus.s[1]};

endmodule

// File: tb/tb_timer_count_dp.sv
// tb_timer_count_dp
// Directed self-checking bench for timer_count_dp. Inputs change 1 ns after
// a rising edge; outputs are checked 1 ns after the following edge.
module tb_timer_count_dp;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    timer_count_dp_if bus ();

    timer_count_dp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " a_min"},    32'(bus.a_min),    0);
        check({tag, " b_sec"},    32'(bus.b_sec),    0);
        check({tag, " r_cnt"},    32'(bus.r_cnt),    0);
        check({tag, " r_zero"},   32'(bus.r_zero),   1);
        check({tag, " k7"},       32'(bus.k7),       0);
        check({tag, " done"},     32'(bus.done),     0);
        check({tag, " disp_min"}, 32'(bus.disp_min), 0);
        check({tag, " disp_sec"}, 32'(bus.disp_sec), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        bus.tick = 1'b0; bus.din = '0;
        bus.La = 1'b0; bus.Lb = 1'b0; bus.Lr = 1'b0;
        bus.Er = 1'b0; bus.Ea = 1'b0; bus.Kc = 1'b0;
        bus.s  = 2'b00;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        step();
        step();
        rst = 1'b0;

        // A=5, B=30, R=330
        bus.din = 6'd5; bus.La = 1'b1;
        step(); bus.La = 1'b0;
        check("a_min=5", 32'(bus.a_min), 5);
        bus.din = 6'd30; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        check("b_sec=30", 32'(bus.b_sec), 30);
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("r_cnt=330", 32'(bus.r_cnt), 330);
        check("r_zero 330", 32'(bus.r_zero), 0);
        bus.Ea = 1'b1; #1;
        check("disp_min 330", 32'(bus.disp_min), 5);
        check("disp_sec 330", 32'(bus.disp_sec), 30);

        // Saturation to 59 and full-range R
        bus.din = 6'd63; bus.La = 1'b1;
        step(); bus.La = 1'b0;
        check("a_min sat", 32'(bus.a_min), 59);
        check("disp_min R held", 32'(bus.disp_min), 5);
        bus.din = 6'd59; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("r_cnt=3599", 32'(bus.r_cnt), 3599);
        check("disp_min 3599", 32'(bus.disp_min), 59);
        check("disp_sec 3599", 32'(bus.disp_sec), 59);
        bus.Ea = 1'b0; bus.din = 6'd62; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        check("Ea=0 disp_sec=B", 32'(bus.disp_sec), 59);

        // R=2, count down to 0, done pulse, no wrap
        bus.din = 6'd0; bus.La = 1'b1;
        step(); bus.La = 1'b0;
        bus.din = 6'd2; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("r_cnt=2", 32'(bus.r_cnt), 2);
        bus.Er = 1'b1; bus.tick = 1'b1;
        step(); bus.tick = 1'b0;
        check("r_cnt=1", 32'(bus.r_cnt), 1);
        check("done low at 1", 32'(bus.done), 0);
        bus.tick = 1'b1;
        step(); bus.tick = 1'b0;
        check("r_cnt=0", 32'(bus.r_cnt), 0);
        check("done pulse", 32'(bus.done), 1);
        check("r_zero at 0", 32'(bus.r_zero), 1);
        step();
        check("done one cycle", 32'(bus.done), 0);
        bus.tick = 1'b1;
        step(); bus.tick = 1'b0;
        check("no wrap r_cnt", 32'(bus.r_cnt), 0);
        check("no wrap done", 32'(bus.done), 0);
        bus.Er = 1'b0;

        // Loading 0 does not raise done
        bus.din = 6'd0; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("load0 r_cnt", 32'(bus.r_cnt), 0);
        check("load0 done", 32'(bus.done), 0);

        // Pause and Lr priority: A=B=1 -> R=61
        bus.din = 6'd1; bus.La = 1'b1; bus.Lb = 1'b1;
        step(); bus.La = 1'b0; bus.Lb = 1'b0;
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("r_cnt=61", 32'(bus.r_cnt), 61);
        bus.Er = 1'b1; bus.s = 2'b01; bus.tick = 1'b1;
        step(); step(); step();
        check("paused r_cnt", 32'(bus.r_cnt), 61);
        bus.s = 2'b00; bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("Lr beats tick", 32'(bus.r_cnt), 61);
        step(); bus.tick = 1'b0;
        check("tick decrements", 32'(bus.r_cnt), 60);
        bus.Er = 1'b0;
        bus.din = 6'd2; bus.La = 1'b1; bus.Lr = 1'b1;
        step(); bus.La = 1'b0; bus.Lr = 1'b0;
        check("La+Lr a_min", 32'(bus.a_min), 2);
        check("La+Lr r_cnt old", 32'(bus.r_cnt), 61);

        // K counter
        bus.Kc = 1'b1;
        step(); bus.Kc = 1'b0;
        check("k7 after Kc", 32'(bus.k7), 0);
        bus.tick = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("k7 after 6 ticks", 32'(bus.k7), 0);
        step();
        check("k7 after 7 ticks", 32'(bus.k7), 1);
        step(); step(); step();
        check("k7 saturates", 32'(bus.k7), 1);
        bus.Kc = 1'b1;
        step(); bus.Kc = 1'b0;
        check("Kc beats tick", 32'(bus.k7), 0);
        bus.tick = 1'b0;

        // Reset mid-countdown with R=100
        bus.din = 6'd1; bus.La = 1'b1;
        step(); bus.La = 1'b0;
        bus.din = 6'd40; bus.Lb = 1'b1;
        step(); bus.Lb = 1'b0;
        bus.Lr = 1'b1;
        step(); bus.Lr = 1'b0;
        check("r_cnt=100", 32'(bus.r_cnt), 100);
        bus.Er = 1'b1; bus.Ea = 1'b1; bus.tick = 1'b1;
        step();
        check("r_cnt=99", 32'(bus.r_cnt), 99);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst mid");
        step();
        check("rst hold done", 32'(bus.done), 0);
        check("rst hold r_cnt", 32'(bus.r_cnt), 0);
        rst = 1'b0; bus.tick = 1'b0; bus.Er = 1'b0; bus.Ea = 1'b0;
        bus.din = 6'd3; bus.La = 1'b1;
        step(); bus.La = 1'b0;
        check("first edge after rst", 32'(bus.a_min), 3);
        check("no done after rst", 32'(bus.done), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
